uart_cmd_tx: RTL
================

UART_CMD_TX -- requirements
Module: uart_cmd_tx

Interface
REQ-001 PAR_TYP, 0, parity sense when parity is compiled in (0 even, 1 odd).
REQ-002 CLK  input  1  single clock; all logic on rising edge.
REQ-003 RST  input  1  synchronous reset, active-high.
REQ-004 TICK  input  1  one-CLK-cycle baud strobe, one per UART bit period.
REQ-005 CMD_VALID  input  1  command request.
REQ-006 CMD_TYPE  input  2  00 RF write, 01 RF read, 10 ALU with operands, 11 ALU without operands.
REQ-007 CMD_ADDR  input  8  register-file address.
REQ-008 CMD_WDATA  input  8  register-file write data.
REQ-009 OP_A  input  8  ALU operand A.
REQ-010 OP_B  input  8  ALU operand B.
REQ-011 ALU_FUN  input  8  ALU function code.
REQ-012 CMD_READY  output  1  high only in IDLE; command accepted when CMD_VALID and CMD_READY are both high on a CLK edge.
REQ-013 TX_OUT  output  1  serial line, idle high.
REQ-014 BUSY  output  1  high from acceptance until the command completes.
REQ-015 DONE  output  1  one-cycle pulse at command completion.

Function
REQ-016 Byte sequences, sent in this order: RF write = 0xAA, ADDR, WDATA; RF read = 0xBB, ADDR; ALU with operands = 0xCC, A, B, FUN; ALU without operands = 0xDD, FUN.
REQ-017 On acceptance, the block latches all payload fields and the command type; later input changes are ignored until the command completes.
REQ-018 Frame format: start bit 0, then 8 data bits LSB first, then the optional parity bit, then stop bit 1.
REQ-019 States: IDLE, START, DATA, PARITY, STOP; a 3-bit bit counter and a 2-bit byte index.
REQ-020 Every state transition and every TX_OUT change happens only on a CLK edge where TICK=1; each bit is held for exactly one TICK period.
REQ-021 IDLE->START occurs on the first TICK strictly after the acceptance edge; TICK in the acceptance cycle itself does not start transmission.
REQ-022 DATA->PARITY (or DATA->STOP when parity is compiled out) occurs after the 8th data bit; PARITY->STOP on the next TICK.
REQ-023 STOP with bytes remaining: the next TICK goes directly to START of the next byte, with no idle gap between frames.
REQ-024 STOP on the last byte: the next TICK goes to IDLE, TX_OUT=1, DONE=1 for that one cycle, and CMD_READY=1 from the following cycle.
REQ-025 CMD_VALID while BUSY is ignored; no queuing.
REQ-026 TICK held high continuously advances one bit per CLK cycle; this is legal.

Reset
REQ-027 RST=1 forces, on the next edge: state IDLE, TX_OUT=1, CMD_READY=1, BUSY=0, DONE=0, counters 0.
REQ-028 Reset mid-frame aborts the command; the partial frame is not resumed, and no DONE pulse is issued.
REQ-029 RST has priority over TICK and CMD_VALID in the same cycle.

Configuration
REQ-030 Macro UART_PARITY_EN defined: 11-bit frames; parity bit = XOR of the data bits, inverted when PAR_TYP=1.
REQ-031 UART_PARITY_EN undefined: 10-bit frames; the PARITY state and its logic are absent, and PAR_TYP is unused.

Structure
REQ-032 Package uart_cmd_pkg holds the opcode constants (0xAA, 0xBB, 0xCC, 0xDD), the CMD_TYPE encodings, and the state encoding.
REQ-033 Sub-module uart_frame_ser serializes one byte (start/data/parity/stop) on TICK, with load/done handshake to the command sequencer.

Verification
REQ-034 Parity on, even; RF write ADDR=0x05 WDATA=0x3C -> bytes AA,05,3C; parity bits 0,0,0; 33 TICKs; DONE after the 33rd bit period.
REQ-035 Parity on, even; ALU CC with A=0x05, B=0x03, FUN=0x01 -> 44 bits; parity bits 0,0,0,1; no idle bits between frames.
REQ-036 Parity on; RF read ADDR=0x02 -> BB then 02; parity 0 then 1 with PAR_TYP=0, and 1 then 0 with PAR_TYP=1.
REQ-037 Parity off; ALU no-operand FUN=0x0F -> frames DD, 0F; 20 TICKs; stop bit directly follows data bit 7.
REQ-038 RST asserted on the 5th data bit of byte 2 -> TX_OUT=1 and CMD_READY=1 on the next edge; no DONE; a new command then transmits correctly.
REQ-039 CMD_VALID held with changing fields while BUSY -> transmitted bytes match the accepted values; the second request is not sent until CMD_READY returns high.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command transmitter: opcodes, command encodings, FSM states.
// UART_PARITY_EN adds the PARITY state; without it frames are start/8 data/stop.
package uart_cmd_pkg;

    localparam logic [7:0] OPC_RF_WR   = 8'hAA;
    localparam logic [7:0] OPC_RF_RD   = 8'hBB;
    localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

    localparam logic [1:0] CMD_RF_WR   = 2'b00;
    localparam logic [1:0] CMD_RF_RD   = 2'b01;
    localparam logic [1:0] CMD_ALU_OP  = 2'b10;
    localparam logic [1:0] CMD_ALU_NOP = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } ser_state_t;

    typedef struct packed {
        logic [1:0] typ;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] op_a;
        logic [7:0] op_b;
        logic [7:0] fun;
    } cmd_t;

    function automatic logic [1:0] cmd_last_idx(input logic [1:0] typ);
        logic [1:0] r_last;
        case (typ)
            CMD_RF_WR:  r_last = 2'd2;
            CMD_ALU_OP: r_last = 2'd3;
            default:    r_last = 2'd1;
        endcase
        return r_last;
    endfunction

    function automatic logic [7:0] cmd_byte(input cmd_t cmd, input logic [1:0] idx);
        logic [7:0] r_b;
        r_b = 8'h00;
        case (cmd.typ)
            CMD_RF_WR: begin
                case (idx)
                    2'd0:    r_b = OPC_RF_WR;
                    2'd1:    r_b = cmd.addr;
                    default: r_b = cmd.wdata;
                endcase
            end
            CMD_RF_RD:  r_b = (idx == 2'd0) ? OPC_RF_RD : cmd.addr;
            CMD_ALU_OP: begin
                case (idx)
                    2'd0:    r_b = OPC_ALU_OP;
                    2'd1:    r_b = cmd.op_a;
                    2'd2:    r_b = cmd.op_b;
                    default: r_b = cmd.fun;
                endcase
            end
            default:    r_b = (idx == 2'd0) ? OPC_ALU_NOP : cmd.fun;
        endcase
        return r_b;
    endfunction

endpackage

// File: rtl/uart_frame_ser.sv
// One-byte UART frame serializer; every state/line change happens on a TICK edge.
// Takes the next byte from STOP directly (no idle gap); UART_PARITY_EN inserts a parity bit.
module uart_frame_ser
    import uart_cmd_pkg::*;
#(
    parameter bit PAR_TYP = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    output logic       o_take,
    output logic       o_done,
    output logic       o_tx
);

    ser_state_t r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_tx;
    logic       w_boundary;

    assign w_boundary = (r_state == ST_IDLE) || (r_state == ST_STOP);
    assign o_take     = i_tick & i_load & w_boundary;
    assign o_done     = i_tick & ~i_load & (r_state == ST_STOP);
    assign o_tx       = r_tx;

`ifdef UART_PARITY_EN
    logic r_par;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_par <= 1'b0;
        end else if (o_take) begin
            r_par <= (^i_byte) ^ PAR_TYP;
        end
    end
`else
    logic w_unused_par_typ;
    assign w_unused_par_typ = PAR_TYP;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_tx      <= 1'b1;
        end else if (i_tick) begin
            case (r_state)
                ST_IDLE, ST_STOP: begin
                    r_bit_cnt <= 3'd0;
                    if (i_load) begin
                        r_state <= ST_START;
                        r_shift <= i_byte;
                        r_tx    <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_tx    <= 1'b1;
                    end
                end
                ST_START: begin
                    r_state <= ST_DATA;
                    r_tx    <= r_shift[0];
                    r_shift <= r_shift >> 1;
                end
                ST_DATA: begin
                    // r_bit_cnt counts data bits already on the line; 7 means d7 is showing
                    if (r_bit_cnt == 3'd7) begin
                        r_bit_cnt <= 3'd0;
`ifdef UART_PARITY_EN
                        r_state   <= ST_PARITY;
                        r_tx      <= r_par;
`else
                        r_state   <= ST_STOP;
                        r_tx      <= 1'b1;
`endif
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    r_state <= ST_STOP;
                    r_tx    <= 1'b1;
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_tx.sv
// Command sequencer: latches a command in IDLE and streams its opcode/payload bytes as UART frames.
// Start waits for the first TICK after acceptance; DONE pulses once, CMD_READY returns the cycle after (parity: UART_PARITY_EN).
module uart_cmd_tx
    import uart_cmd_pkg::*;
#(
    parameter bit PAR_TYP = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_cmd_valid,
    input  logic [1:0] i_cmd_type,
    input  logic [7:0] i_cmd_addr,
    input  logic [7:0] i_cmd_wdata,
    input  logic [7:0] i_op_a,
    input  logic [7:0] i_op_b,
    input  logic [7:0] i_alu_fun,
    output logic       o_cmd_ready,
    output logic       o_tx_out,
    output logic       o_busy,
    output logic       o_done
);

    cmd_t       r_cmd;
    logic [1:0] r_byte_idx;
    logic       r_all_sent;
    logic       r_ready;
    logic       r_busy;
    logic       r_done;

    logic       w_accept;
    logic       w_load;
    logic       w_take;
    logic       w_frame_done;
    logic [7:0] w_byte;

    assign w_accept = i_cmd_valid & r_ready;
    // Nothing is offered to the serializer until the cycle after acceptance
    assign w_load   = r_busy & ~r_all_sent;
    assign w_byte   = cmd_byte(r_cmd, r_byte_idx);

    uart_frame_ser #(
        .PAR_TYP (PAR_TYP)
    ) u_ser (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_tick (i_tick),
        .i_load (w_load),
        .i_byte (w_byte),
        .o_take (w_take),
        .o_done (w_frame_done),
        .o_tx   (o_tx_out)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cmd      <= '0;
            r_byte_idx <= 2'd0;
            r_all_sent <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_cmd      <= '{typ: i_cmd_type, addr: i_cmd_addr, wdata: i_cmd_wdata,
                                op_a: i_op_a, op_b: i_op_b, fun: i_alu_fun};
                r_byte_idx <= 2'd0;
                r_all_sent <= 1'b0;
                r_ready    <= 1'b0;
                r_busy     <= 1'b1;
            end
            if (w_take) begin
                if (r_byte_idx == cmd_last_idx(r_cmd.typ)) begin
                    r_all_sent <= 1'b1;
                end else begin
                    r_byte_idx <= r_byte_idx + 2'd1;
                end
            end
            if (w_frame_done) begin
                r_done <= 1'b1;
            end
            if (r_done) begin
                r_ready <= 1'b1;
                r_busy  <= 1'b0;
            end
        end
    end

    assign o_cmd_ready = r_ready;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule
